// File: rtl/rr_pkg.sv
// rr_pkg: shared types and helpers for the log reader.
// Holds the reader FSM state type, AXI constants and burst sizing.
package rr_pkg;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_ISSUE,
    RD_WAIT,
    RD_DONE
  } rr_rd_state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // cfg 0..3 selects 128/256/512/1024 byte read requests.
  function automatic logic [12:0] max_read_beats(
    input logic [1:0] cfg,
    input int         beat_bytes
  );
    int b;
    b = (128 << cfg) / beat_bytes;
    if (b < 1) b = 1;
    return 13'(b);
  endfunction

endpackage

// File: rtl/rr_logreader_if.sv
// rr_logreader_if: AXI4 read address/data channels.
// master drives AR and rready; slave drives arready and R.
interface rr_logreader_if #(
  parameter int WIDTH = 512,
  parameter int AW    = 64
);
  logic [AW-1:0]    araddr;
  logic [7:0]       arlen;
  logic [2:0]       arsize;
  logic [1:0]       arburst;
  logic [15:0]      arid;
  logic             arvalid;
  logic             arready;
  logic [WIDTH-1:0] rdata;
  logic [1:0]       rresp;
  logic [15:0]      rid;
  logic             rlast;
  logic             rvalid;
  logic             rready;

  modport master (
    output araddr, arlen, arsize, arburst,
    output arid, arvalid, rready,
    input  arready, rdata, rresp, rid,
    input  rlast, rvalid
  );

  modport slave (
    input  araddr, arlen, arsize, arburst,
    input  arid, arvalid, rready,
    output arready, rdata, rresp, rid,
    output rlast, rvalid
  );
endinterface

// File: rtl/rr_sync_fifo.sv
// rr_sync_fifo: single-clock FIFO, first-word fall-through.
// Ports: wr_en/wr_data, rd_en/rd_data, empty, full, count.
module rr_sync_fifo #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 64
) (
  input  logic                   clk,
  input  logic                   sync_rst,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pull;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign push    = wr_en && !full;
  assign pull    = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pull) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push)
                     - (AW+1)'(pull);
    end
  end
endmodule

// File: rtl/rr_logreader.sv
// rr_logreader: fetches a host log over AXI4 read and streams it out.
// Ports: clk/sync_rst, cfg/start/base_addr/total_len, busy/done/error,
//        dout/dout_valid/dout_ready stream, axi AR/R master.
module rr_logreader
  import rr_pkg::*;
#(
  parameter int WIDTH       = 512,
  parameter int OFFSETWIDTH = 64,
  parameter int LENWIDTH    = 32,
  parameter int FIFO_DEPTH  = 64,
  parameter int ARID_VAL    = 0
) (
  input  logic                   clk,
  input  logic                   sync_rst,
  input  logic [1:0]             cfg_max_read_req,
  input  logic                   start,
  input  logic [OFFSETWIDTH-1:0] base_addr,
  input  logic [LENWIDTH-1:0]    total_len,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [WIDTH-1:0]       dout,
  output logic                   dout_valid,
  input  logic                   dout_ready,
  rr_logreader_if.master         axi
);
  localparam int BB  = WIDTH / 8;
  localparam int BL  = $clog2(BB);
  localparam int CW  = $clog2(FIFO_DEPTH);
  localparam int CAP = (FIFO_DEPTH < 256) ? FIFO_DEPTH : 256;
  localparam logic [OFFSETWIDTH-1:0] AMASK =
    ~OFFSETWIDTH'(BB - 1);

  rr_rd_state_t           state;
  logic [OFFSETWIDTH-1:0] cur_addr;
  logic [OFFSETWIDTH-1:0] araddr_q;
  logic [OFFSETWIDTH-1:0] src_addr;
  logic [LENWIDTH-1:0]    remaining;
  logic [LENWIDTH-1:0]    src_rem;
  logic [CW:0]            inflight;
  logic [CW:0]            fifo_count;
  logic [CW+1:0]          free;
  logic [7:0]             arlen_q;
  logic [8:0]             ar_beats;
  logic [12:0]            mx;
  logic [12:0]            b4k;
  logic [12:0]            blen;
  logic                   arvalid_q;
  logic                   room;
  logic                   start_ok;
  logic                   ar_fire;
  logic                   r_fire;
  logic                   r_bad;
  logic                   r_push;
  logic                   pop;
  logic                   empty;
  logic                   fifo_full;
  logic                   unused_bits;

  assign start_ok = start && !busy
                 && (state == RD_IDLE);

  // In IDLE the burst is sized from the request
  // inputs so the first AR can go out right away.
  assign src_addr = (state == RD_IDLE)
                  ? (base_addr & AMASK) : cur_addr;
  assign src_rem  = (state == RD_IDLE)
                  ? total_len : remaining;

  always_comb begin
    mx = max_read_beats(cfg_max_read_req, BB);
    if (mx > 13'(CAP)) mx = 13'(CAP);
    b4k  = (13'd4096 - {1'b0, src_addr[11:0]}) >> BL;
    blen = (b4k < mx) ? b4k : mx;
    if (src_rem < LENWIDTH'(blen))
      blen = 13'(src_rem);
  end

  // Room counts buffered plus still-owed beats, so
  // every R beat always has a FIFO slot waiting.
  assign free = (CW+2)'(FIFO_DEPTH)
              - (CW+2)'(fifo_count)
              - (CW+2)'(inflight);
  assign room = 32'(free) >= 32'(blen);

  assign ar_beats = {1'b0, arlen_q} + 9'd1;
  assign ar_fire  = arvalid_q && axi.arready;
  assign r_fire   = axi.rvalid && axi.rready;
  assign r_push   = r_fire && (inflight != '0);
  assign r_bad    = (axi.rresp != AXI_RESP_OKAY)
                 || (axi.rid != 16'(ARID_VAL))
                 || (inflight == '0);
  assign pop      = dout_valid && dout_ready;

  assign axi.araddr  = araddr_q;
  assign axi.arlen   = arlen_q;
  assign axi.arsize  = 3'(BL);
  assign axi.arburst = AXI_BURST_INCR;
  assign axi.arid    = 16'(ARID_VAL);
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = !sync_rst;
  assign dout_valid  = !empty;
  assign unused_bits = axi.rlast ^ fifo_full;

  rr_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .sync_rst (sync_rst),
    .wr_en    (r_push),
    .wr_data  (axi.rdata),
    .rd_en    (pop),
    .rd_data  (dout),
    .empty    (empty),
    .full     (fifo_full),
    .count    (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      inflight <= '0;
    end else begin
      inflight <= inflight
        + (ar_fire ? (CW+1)'(ar_beats) : '0)
        - (CW+1)'(r_push);
    end
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state     <= RD_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      cur_addr  <= '0;
      remaining <= '0;
    end else begin
      done <= 1'b0;
      if (done) busy <= 1'b0;
      if (start_ok)
        error <= 1'b0;
      else if (r_fire && r_bad)
        error <= 1'b1;
      unique case (state)
        RD_IDLE: begin
          if (start_ok) begin
            busy      <= 1'b1;
            cur_addr  <= src_addr;
            remaining <= total_len;
            if (total_len == '0) begin
              state <= RD_DONE;
            end else begin
              state <= RD_ISSUE;
              if (room) begin
                arvalid_q <= 1'b1;
                araddr_q  <= src_addr;
                arlen_q   <= 8'(blen - 13'd1);
              end
            end
          end
        end
        RD_ISSUE: begin
          if (arvalid_q) begin
            if (axi.arready) begin
              arvalid_q <= 1'b0;
              cur_addr  <= cur_addr
                + (OFFSETWIDTH'(ar_beats) << BL);
              remaining <= remaining
                - LENWIDTH'(ar_beats);
              if (remaining == LENWIDTH'(ar_beats))
                state <= RD_WAIT;
            end
          end else if (room) begin
            arvalid_q <= 1'b1;
            araddr_q  <= cur_addr;
            arlen_q   <= 8'(blen - 13'd1);
          end
        end
        RD_WAIT: begin
          if (inflight == '0 && empty)
            state <= RD_DONE;
        end
        RD_DONE: begin
          done  <= 1'b1;
          state <= RD_IDLE;
        end
      endcase
    end
  end
endmodule
